// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, the instruction memory and the decode stage.
// The master view belongs to the fetch stage. The slave view belongs to its surroundings.
interface fetch_stage_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [DATA_W-1:0] imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_addr, imem_en, inst_valid, inst_data, inst_pc,
    input  imem_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_addr, imem_en, inst_valid, inst_data, inst_pc,
    output imem_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end. It issues PCs to a synchronous-read imem and buffers the returned
// words with their PCs in a small FIFO. A redirect flushes every buffered and in-flight fetch.
module fetch_stage #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 2
) (
  input logic         clk,
  input logic         reset,
  fetch_stage_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 2;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  cnt_t              count;
  logic              inflight;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic              issue, push, pop, head_valid;
  cnt_t              occupancy;

  assign head_valid = (count != '0) & !bus.redirect_valid;
  assign pop        = head_valid & bus.inst_ready;
  assign push       = inflight & !bus.redirect_valid;

  // A fetch is issued only when its word is certain to find a free slot on return.
  // Gating with reset keeps imem quiet while reset is asserted.
  assign occupancy  = count + cnt_t'(inflight) - cnt_t'(pop);
  assign issue      = reset & !bus.redirect_valid & (occupancy < cnt_t'(DEPTH));

  assign bus.imem_addr  = fetch_pc;
  assign bus.imem_en    = issue;
  assign bus.inst_valid = head_valid;
  assign bus.inst_data  = mem_data[rd_ptr];
  assign bus.inst_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= ADDR_W'(RESET_PC);
      req_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      // The word that returns on the next cycle belongs to the old path. Clearing inflight drops it.
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        req_pc   <= fetch_pc;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end

      if (push) begin
        mem_data[wr_ptr] <= bus.imem_data;
        mem_pc[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  overflow_check: assert property (@(posedge clk) disable iff (!reset)
    push |-> ((count < cnt_t'(DEPTH)) || pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. It covers startup latency, streaming, stall, PC wrap,
// redirects and asynchronous reset, with imem returning 0xA000_0000 + address.
module tb_fetch_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_stage_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  fetch_stage #(
    .ADDR_W(6), .DATA_W(32), .RESET_PC(0), .DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory model.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_data <= 32'hA000_0000 + {26'd0, bus.imem_addr};
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string tag, input logic exp_valid, input logic [5:0] exp_pc);
    check_output({tag, "_valid"}, {31'd0, bus.inst_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check_output({tag, "_pc"}, {26'd0, bus.inst_pc}, {26'd0, exp_pc});
      check_output({tag, "_data"}, bus.inst_data, 32'hA000_0000 + {26'd0, exp_pc});
    end
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.imem_data      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b1;

    #2;
    check_output("rst_imem_en", {31'd0, bus.imem_en}, 32'd0);
    check_output("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_output("rst_pc", {26'd0, bus.inst_pc}, 32'd0);
    check_output("rst_data", bus.inst_data, 32'd0);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("start_en", {31'd0, bus.imem_en}, 32'd1);
    check_output("start_addr", {26'd0, bus.imem_addr}, 32'd0);

    apply_stimulus();
    check_inst("edge1", 1'b0, 6'd0);
    apply_stimulus();
    check_inst("edge2", 1'b1, 6'd0);
    for (int p = 1; p <= 4; p++) begin
      apply_stimulus();
      check_inst("stream", 1'b1, 6'(p));
    end

    // Stall while the head is pc 4.
    bus.inst_ready = 1'b0;
    #1;
    check_output("stall_en0", {31'd0, bus.imem_en}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      apply_stimulus();
      check_inst("stall_hold", 1'b1, 6'd4);
      check_output("stall_en", {31'd0, bus.imem_en}, 32'd0);
    end
    bus.inst_ready = 1'b1;
    #1;
    check_output("release_en", {31'd0, bus.imem_en}, 32'd1);
    check_output("release_addr", {26'd0, bus.imem_addr}, 32'd6);

    for (int p = 5; p <= 63; p++) begin
      apply_stimulus();
      check_inst("run", 1'b1, 6'(p));
    end
    apply_stimulus();
    check_inst("wrap", 1'b1, 6'd0);

    // Redirect with a word in flight.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 6'd20;
    #1;
    check_output("redir_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_output("redir_en", {31'd0, bus.imem_en}, 32'd0);
    apply_stimulus();
    bus.redirect_valid = 1'b0;
    #1;
    check_output("redir_issue_en", {31'd0, bus.imem_en}, 32'd1);
    check_output("redir_issue_addr", {26'd0, bus.imem_addr}, 32'd20);
    check_inst("redir_empty", 1'b0, 6'd0);
    apply_stimulus();
    check_inst("redir_gap", 1'b0, 6'd0);
    apply_stimulus();
    check_inst("redir_first", 1'b1, 6'd20);
    apply_stimulus();
    check_inst("redir_next", 1'b1, 6'd21);

    // Fill the FIFO, then issue back-to-back redirects.
    bus.inst_ready = 1'b0;
    apply_stimulus();
    check_inst("fill_hold", 1'b1, 6'd21);
    check_output("fill_en", {31'd0, bus.imem_en}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 6'd10;
    #1;
    check_output("b2b_valid1", {31'd0, bus.inst_valid}, 32'd0);
    apply_stimulus();
    bus.redirect_pc = 6'd30;
    #1;
    check_output("b2b_valid2", {31'd0, bus.inst_valid}, 32'd0);
    check_output("b2b_en2", {31'd0, bus.imem_en}, 32'd0);
    apply_stimulus();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    #1;
    check_output("b2b_addr", {26'd0, bus.imem_addr}, 32'd30);
    check_output("b2b_en", {31'd0, bus.imem_en}, 32'd1);
    apply_stimulus();
    check_inst("b2b_gap", 1'b0, 6'd0);
    for (int p = 30; p <= 32; p++) begin
      apply_stimulus();
      check_inst("b2b_stream", 1'b1, 6'(p));
    end

    // Asynchronous reset between edges.
    #3;
    reset = 1'b0;
    #1;
    check_output("async_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_output("async_en", {31'd0, bus.imem_en}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("restart_addr", {26'd0, bus.imem_addr}, 32'd0);
    check_output("restart_en", {31'd0, bus.imem_en}, 32'd1);
    apply_stimulus();
    check_inst("restart_edge1", 1'b0, 6'd0);
    apply_stimulus();
    check_inst("restart_edge2", 1'b1, 6'd0);
    apply_stimulus();
    check_inst("restart_edge3", 1'b1, 6'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
